// File: rtl/mem_pkg.sv
// Shared constants and types for the memory-access stage.
package mem_pkg;

    // Bit positions inside the one-hot store pick vector
    localparam int unsigned SW_B  = 0;
    localparam int unsigned SH_B  = 1;
    localparam int unsigned SB_B  = 2;
    localparam int unsigned SWL_B = 3;
    localparam int unsigned SWR_B = 4;

    // Bit positions inside the one-hot register write-source vector
    localparam int unsigned LB_B  = 7;
    localparam int unsigned LBU_B = 8;
    localparam int unsigned LH_B  = 9;
    localparam int unsigned LHU_B = 10;
    localparam int unsigned LWL_B = 11;
    localparam int unsigned LWR_B = 12;
    localparam int unsigned LW_B  = 13;

    // Width of the load-type slice [LW_B:LB_B] handed to the lane aligner
    localparam int unsigned LOAD_SEL_W = LW_B - LB_B + 1;

    // Memory-port handshake states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian byte-lane alignment: store strobes/data and load
// extraction, sign/zero extension and LWL/LWR merging. Purely combinational.
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [4:0]            store_pick,
    input  logic [1:0]            store_off,
    input  logic [31:0]           store_b,
    output logic [3:0]            wstrb,
    output logic [31:0]           wdata,
    input  logic [LOAD_SEL_W-1:0] load_sel,
    input  logic [1:0]            load_off,
    input  logic [31:0]           rdata,
    input  logic [31:0]           rt,
    output logic [31:0]           load_data
);

    logic [4:0]  up_shift;
    logic [4:0]  dn_shift;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // 8*off and 8*(3-off); for a 2-bit offset, 3-off is just ~off
    assign up_shift = {store_off, 3'b000};
    assign dn_shift = {~store_off, 3'b000};

    // Store side: strobes and lane-replicated / shifted data
    always_comb begin
        wstrb = '0;
        wdata = '0;
        if (store_pick[SW_B]) begin
            wstrb = 4'b1111;
            wdata = store_b;
        end else if (store_pick[SH_B]) begin
            wstrb = store_off[1] ? 4'b1100 : 4'b0011;
            wdata = {store_b[15:0], store_b[15:0]};
        end else if (store_pick[SB_B]) begin
            wstrb = 4'b0001 << store_off;
            wdata = {4{store_b[7:0]}};
        end else if (store_pick[SWL_B]) begin
            wstrb = 4'b1111 >> ~store_off;
            wdata = store_b >> dn_shift;
        end else if (store_pick[SWR_B]) begin
            wstrb = 4'b1111 << store_off;
            wdata = store_b << up_shift;
        end
    end

    assign byte_v = 8'(rdata >> {load_off, 3'b000});
    assign half_v = load_off[1] ? rdata[31:16] : rdata[15:0];

    // Load side: extract and extend, or merge with rt; no type bit means lw
    always_comb begin
        load_data = rdata;
        if (load_sel[LB_B - LB_B]) begin
            load_data = {{24{byte_v[7]}}, byte_v};
        end else if (load_sel[LBU_B - LB_B]) begin
            load_data = {24'd0, byte_v};
        end else if (load_sel[LH_B - LB_B]) begin
            load_data = {{16{half_v[15]}}, half_v};
        end else if (load_sel[LHU_B - LB_B]) begin
            load_data = {16'd0, half_v};
        end else if (load_sel[LWL_B - LB_B]) begin
            case (load_off)
                2'd0:    load_data = {rdata[7:0],  rt[23:0]};
                2'd1:    load_data = {rdata[15:0], rt[15:0]};
                2'd2:    load_data = {rdata[23:0], rt[7:0]};
                default: load_data = rdata;
            endcase
        end else if (load_sel[LWR_B - LB_B]) begin
            case (load_off)
                2'd0:    load_data = rdata;
                2'd1:    load_data = {rt[31:24], rdata[31:8]};
                2'd2:    load_data = {rt[31:16], rdata[31:16]};
                default: load_data = {rt[31:8],  rdata[31:24]};
            endcase
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: single-instruction FSM driving a req/addr_ok/data_ok
// data port and presenting one registered write-back result.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mem_wen_pick,
    input  logic              in_mem_read,
    input  logic              in_reg_write,
    input  logic [15:0]       in_reg_write_src,
    input  logic [31:0]       in_alu_result,
    input  logic [31:0]       in_store_data,
    input  logic [4:0]        in_dest,
    output logic              data_req,
    output logic              data_wr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_we,
    output logic [4:0]        out_dest,
    output logic [31:0]       out_data
);

    state_t                  state;
    logic [31:0]             alu_q;
    logic [31:0]             rt_q;
    logic [LOAD_SEL_W-1:0]   load_sel_q;
    logic                    is_store_q;

    logic                    is_store;
    logic                    is_mem;
    logic [3:0]              st_wstrb;
    logic [31:0]             st_wdata;
    logic [31:0]             ld_data;
    logic [31:0]             resp_data;
    logic                    unused_src;

    assign is_store   = |in_mem_wen_pick;
    assign is_mem     = is_store | in_mem_read;
    assign unused_src = ^{in_reg_write_src[15:LW_B+1], in_reg_write_src[LB_B-1:0]};

    // Store side works on the incoming instruction so the request is
    // registered at accept; load side works on the latched instruction and
    // the live read bus so the merged word is registered on data_ok.
    lsu_lane_align u_align (
        .store_pick (in_mem_wen_pick),
        .store_off  (in_alu_result[1:0]),
        .store_b    (in_store_data),
        .wstrb      (st_wstrb),
        .wdata      (st_wdata),
        .load_sel   (load_sel_q),
        .load_off   (alu_q[1:0]),
        .rdata      (data_rdata),
        .rt         (rt_q),
        .load_data  (ld_data)
    );

    // Stores retire with the address as a don't-care payload
    assign resp_data = is_store_q ? alu_q : ld_data;

    // Handshake FSM with registered port and write-back outputs; the
    // out_data register doubles as the captured read word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_addr  <= '0;
            data_wstrb <= '0;
            data_wdata <= '0;
            out_valid  <= 1'b0;
            out_we     <= 1'b0;
            out_dest   <= '0;
            out_data   <= '0;
            alu_q      <= '0;
            rt_q       <= '0;
            load_sel_q <= '0;
            is_store_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready   <= 1'b0;
                        alu_q      <= in_alu_result;
                        rt_q       <= in_store_data;
                        load_sel_q <= in_reg_write_src[LW_B:LB_B];
                        is_store_q <= is_store;
                        out_dest   <= in_dest;
                        out_we     <= is_store ? 1'b0 : in_reg_write;
                        if (is_mem) begin
                            state      <= REQ;
                            data_req   <= 1'b1;
                            data_wr    <= is_store;
                            data_addr  <= {in_alu_result[ADDR_W-1:2], 2'b00};
                            data_wstrb <= st_wstrb;
                            data_wdata <= st_wdata;
                        end else begin
                            state     <= RESP;
                            out_valid <= 1'b1;
                            out_data  <= in_alu_result;
                        end
                    end
                end
                REQ: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        if (data_data_ok) begin
                            state     <= RESP;
                            out_valid <= 1'b1;
                            out_data  <= resp_data;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (data_data_ok) begin
                        state     <= RESP;
                        out_valid <= 1'b1;
                        out_data  <= resp_data;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
